// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core: FETCH/DECODE/EXECUTE/MEM/WB over shared registers,
// one valid/ready memory port for both instruction fetch and data access.
module multicycle_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              retire,
   output logic [ADDR_W-1:0] retire_pc,
   output logic              halted
);

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEM     = 3'd3,
      ST_WB      = 3'd4,
      ST_HALT    = 3'd5
   } state_t;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_STORE= 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;

   state_t             state_reg, state_next;
   logic [ADDR_W-1:0]  pc_reg;
   logic [31:0]        ir_reg;
   logic [31:0]        a_reg;
   logic [31:0]        b_reg;
   logic [31:0]        alu_out_reg;
   logic [31:0]        mdr_reg;
   logic [31:0]        rf_reg [32];

   // Instruction fields, decoded from IR (stable from DECODE until the next FETCH)
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_b;

   assign opcode = ir_reg[6:0];
   assign rd     = ir_reg[11:7];
   assign funct3 = ir_reg[14:12];
   assign rs1    = ir_reg[19:15];
   assign rs2    = ir_reg[24:20];
   assign funct7 = ir_reg[31:25];
   assign imm_i  = {{20{ir_reg[31]}}, ir_reg[31:20]};
   assign imm_s  = {{20{ir_reg[31]}}, ir_reg[31:25], ir_reg[11:7]};
   assign imm_b  = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0};

   logic is_r, is_i, is_lw, is_sw, is_beq, r_ok, i_ok, legal;

   assign is_r   = (opcode == OP_R);
   assign is_i   = (opcode == OP_IMM);
   assign is_lw  = (opcode == OP_LOAD)  && (funct3 == 3'b010);
   assign is_sw  = (opcode == OP_STORE) && (funct3 == 3'b010);
   assign is_beq = (opcode == OP_BR)    && (funct3 == 3'b000);

   // sltu/sltiu (funct3=011) are outside the subset; only add/sub and srl/sra take funct7=0x20
   always_comb begin
      r_ok = 1'b0;
      i_ok = 1'b0;
      case (funct3)
         3'b000, 3'b101: r_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
         3'b011:         r_ok = 1'b0;
         default:        r_ok = (funct7 == 7'h00);
      endcase
      case (funct3)
         3'b001:  i_ok = (funct7 == 7'h00);
         3'b101:  i_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
         3'b011:  i_ok = 1'b0;
         default: i_ok = 1'b1;
      endcase
   end

   assign legal = (is_r && r_ok) || (is_i && i_ok) || is_lw || is_sw || is_beq;

   logic [31:0] op_b, alu_value, addr_sum, alu_result;

   assign op_b     = is_r ? b_reg : imm_i;
   assign addr_sum = a_reg + (is_sw ? imm_s : imm_i);

   always_comb begin
      alu_value = a_reg + op_b;
      case (funct3)
         3'b000:  alu_value = (is_r && funct7[5]) ? (a_reg - op_b) : (a_reg + op_b);
         3'b001:  alu_value = a_reg << op_b[4:0];
         3'b010:  alu_value = {31'b0, $signed(a_reg) < $signed(op_b)};
         3'b100:  alu_value = a_reg ^ op_b;
         3'b101:  alu_value = funct7[5] ? 32'($signed(a_reg) >>> op_b[4:0]) : (a_reg >> op_b[4:0]);
         3'b110:  alu_value = a_reg | op_b;
         3'b111:  alu_value = a_reg & op_b;
         default: alu_value = a_reg + op_b;
      endcase
   end

   assign alu_result = (is_lw || is_sw) ? addr_sum : alu_value;

   logic              beq_taken, br_misalign, mem_misalign;
   logic [ADDR_W-1:0] pc_plus4, pc_branch;

   assign beq_taken    = (a_reg == b_reg);
   assign pc_plus4     = pc_reg + ADDR_W'(4);
   assign pc_branch    = pc_reg + imm_b[ADDR_W-1:0];
   // A taken branch to a non-word address would make the next fetch misaligned
   assign br_misalign  = is_beq && beq_taken && imm_b[1];
   assign mem_misalign = (is_lw || is_sw) && (alu_result[1:0] != 2'b00);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_FETCH:   if (mem_ready) state_next = ST_DECODE;
         ST_DECODE:  state_next = legal ? ST_EXECUTE : ST_HALT;
         ST_EXECUTE: begin
            if (br_misalign || mem_misalign) state_next = ST_HALT;
            else if (is_beq)                 state_next = ST_FETCH;
            else if (is_lw || is_sw)         state_next = ST_MEM;
            else                             state_next = ST_WB;
         end
         ST_MEM:     if (mem_ready) state_next = is_sw ? ST_FETCH : ST_WB;
         ST_WB:      state_next = ST_FETCH;
         ST_HALT:    state_next = ST_HALT;
         default:    state_next = ST_HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) state_reg <= ST_FETCH;
      else      state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_reg      <= RESET_PC[ADDR_W-1:0];
         ir_reg      <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         alu_out_reg <= '0;
         mdr_reg     <= '0;
      end else begin
         case (state_reg)
            ST_FETCH:  if (mem_ready) ir_reg <= mem_rdata;
            ST_DECODE: begin
               a_reg <= rf_reg[rs1];
               b_reg <= rf_reg[rs2];
            end
            ST_EXECUTE: begin
               alu_out_reg <= alu_result;
               if (is_beq && !br_misalign) pc_reg <= beq_taken ? pc_branch : pc_plus4;
            end
            ST_MEM: begin
               if (mem_ready) begin
                  if (is_sw) pc_reg  <= pc_plus4;
                  else       mdr_reg <= mem_rdata;
               end
            end
            ST_WB:     pc_reg <= pc_plus4;
            default:   ;
         endcase
      end
   end

   // x0 is never written, so it keeps its reset value of zero
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) rf_reg[i] <= '0;
      end else if (state_reg == ST_WB && rd != 5'd0) begin
         rf_reg[rd] <= is_lw ? mdr_reg : alu_out_reg;
      end
   end

   // Outputs are forced idle while reset is low so an in-flight request drops at once
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      retire    = 1'b0;
      halted    = 1'b0;
      if (rst) begin
         case (state_reg)
            ST_FETCH: begin
               mem_req  = 1'b1;
               mem_addr = pc_reg;
            end
            ST_EXECUTE: retire = is_beq && !br_misalign;
            ST_MEM: begin
               mem_req   = 1'b1;
               mem_we    = is_sw;
               mem_addr  = alu_out_reg[ADDR_W-1:0];
               mem_wdata = is_sw ? b_reg : 32'h0;
               retire    = is_sw && mem_ready;
            end
            ST_WB:   retire = 1'b1;
            ST_HALT: halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign retire_pc = pc_reg;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: small hand-assembled program, unified memory model
// with per-address stall injection, halt and reset-abort scenarios.
module tb_multicycle_core;

   localparam int OP_IMM  = 7'h13;
   localparam int OP_LOAD = 7'h03;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req, mem_we, mem_ready, retire, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, retire_pc;

   multicycle_core #(.RESET_PC(32'h0000_0100), .ADDR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .retire    (retire),
      .retire_pc (retire_pc),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory model: stalls only the configured data address, stall_n cycles per access
   logic [31:0] mem_words [0:255];
   logic [31:0] stall_addr = 32'd8;
   int          stall_n    = 0;
   int          wait_cnt   = 0;
   int          cyc        = 0;

   assign mem_rdata = mem_words[mem_addr[9:2]];
   assign mem_ready = !((mem_addr == stall_addr) && (wait_cnt < stall_n));

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) wait_cnt <= 0;
      else if (mem_req) wait_cnt <= mem_ready ? 0 : wait_cnt + 1;
      if (mem_req && mem_ready && mem_we) mem_words[mem_addr[9:2]] <= mem_wdata;
   end

   logic [31:0] ret_pc_q [$];
   int          ret_cyc_q [$];
   logic [31:0] last_req_addr = '0;
   int          stall_cycles = 0;
   int          stable_err = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr, prev_wdata;
   logic        prev_we;
   logic        halt_seen = 1'b0;
   int          halt_cyc = 0;

   always @(negedge clk) begin
      if (retire) begin
         ret_pc_q.push_back(retire_pc);
         ret_cyc_q.push_back(cyc);
         $display("retire pc=%h cyc=%0d", retire_pc, cyc);
      end
      if (mem_req) last_req_addr <= mem_addr;
      if (mem_req && !mem_ready) stall_cycles <= stall_cycles + 1;
      if (prev_stall && mem_req &&
          (mem_addr != prev_addr || mem_we != prev_we || mem_wdata != prev_wdata))
         stable_err <= stable_err + 1;
      prev_stall <= mem_req && !mem_ready;
      prev_addr  <= mem_addr;
      prev_we    <= mem_we;
      prev_wdata <= mem_wdata;
      if (halted && !halt_seen) begin
         halt_seen <= 1'b1;
         halt_cyc  <= cyc;
      end
      if (!rst) halt_seen <= 1'b0;
   end

   function automatic logic [31:0] enc_r(int f7, int f3, int rd, int rs1, int rs2);
      logic [31:0] a7, a3, ad, a1, a2;
      a7 = f7; a3 = f3; ad = rd; a1 = rs1; a2 = rs2;
      return {a7[6:0], a2[4:0], a1[4:0], a3[2:0], ad[4:0], 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(int op, int f3, int rd, int rs1, int imm);
      logic [31:0] ao, a3, ad, a1, v;
      ao = op; a3 = f3; ad = rd; a1 = rs1; v = imm;
      return {v[11:0], a1[4:0], a3[2:0], ad[4:0], ao[6:0]};
   endfunction

   function automatic logic [31:0] enc_s(int rs2, int rs1, int imm);
      logic [31:0] a2, a1, v;
      a2 = rs2; a1 = rs1; v = imm;
      return {v[11:5], a2[4:0], a1[4:0], 3'b010, v[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(int rs1, int rs2, int imm);
      logic [31:0] a2, a1, v;
      a2 = rs2; a1 = rs1; v = imm;
      return {v[12], v[10:5], a2[4:0], a1[4:0], 3'b000, v[4:1], v[11], 7'b1100011};
   endfunction

   // Expected retire sequence: PC and cycles taken by that instruction
   logic [31:0] exp_pc [22] = '{
      32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118, 32'h11C,
      32'h120, 32'h124, 32'h128, 32'h12C, 32'h138, 32'h130, 32'h134, 32'h140,
      32'h144, 32'h148, 32'h14C, 32'h150, 32'h154, 32'h158};
   int exp_gap [22] = '{0, 4, 4, 4, 4, 7, 8, 4, 4, 4, 3, 3, 3, 4, 3, 4, 4, 4, 4, 4, 4, 4};

   int rel_cyc;
   int ret_before;
   bit found;

   initial begin
      for (int i = 0; i < 256; i++) mem_words[i] = 32'h0;
      mem_words[6]  = 32'hDEAD_BEEF;
      mem_words[64] = enc_i(OP_IMM, 0, 1, 0, 5);        // addi x1,x0,5
      mem_words[65] = enc_i(OP_IMM, 0, 2, 0, -3);       // addi x2,x0,-3
      mem_words[66] = enc_r(0, 0, 3, 1, 2);             // add  x3,x1,x2
      mem_words[67] = enc_r(32, 0, 4, 2, 1);            // sub  x4,x2,x1
      mem_words[68] = enc_r(0, 2, 5, 2, 1);             // slt  x5,x2,x1
      mem_words[69] = enc_s(3, 0, 8);                   // sw   x3,8(x0)
      mem_words[70] = enc_i(OP_LOAD, 2, 6, 0, 8);       // lw   x6,8(x0)
      mem_words[71] = enc_s(4, 0, 12);
      mem_words[72] = enc_s(5, 0, 16);
      mem_words[73] = enc_s(6, 0, 20);
      mem_words[74] = enc_b(1, 2, 12);                  // beq x1,x2,+12 not taken
      mem_words[75] = enc_b(0, 0, 12);                  // -> 0x138
      mem_words[76] = enc_i(OP_IMM, 0, 0, 0, 7);        // addi x0,x0,7
      mem_words[77] = enc_b(0, 0, 12);                  // -> 0x140
      mem_words[78] = enc_b(1, 1, -8);                  // -> 0x130
      mem_words[80] = enc_r(0, 0, 8, 0, 0);             // add  x8,x0,x0
      mem_words[81] = enc_s(8, 0, 24);
      mem_words[82] = enc_r(32, 5, 9, 4, 1);            // sra  x9,x4,x1
      mem_words[83] = enc_r(0, 5, 10, 4, 1);            // srl  x10,x4,x1
      mem_words[84] = enc_s(9, 0, 28);
      mem_words[85] = enc_s(10, 0, 32);
      mem_words[86] = enc_i(OP_IMM, 0, 7, 0, 85);       // addi x7,x0,0x55
      mem_words[87] = enc_i(OP_LOAD, 2, 7, 0, 2);       // lw   x7,2(x0) misaligned
      stall_n = 3;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_retire", {31'b0, retire}, 32'd0);
      chk("rst_halted", {31'b0, halted}, 32'd0);

      @(negedge clk);
      rst = 1'b1;
      rel_cyc = cyc;
      #1;
      chk("first_req", {31'b0, mem_req}, 32'd1);
      chk("first_addr", mem_addr, 32'h100);
      chk("first_we", {31'b0, mem_we}, 32'd0);

      for (int i = 0; i < 600 && !halted; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      #1;
      chk("prog_halted", {31'b0, halted}, 32'd1);
      chk("ret_count", ret_pc_q.size(), 32'd22);
      chk("first_ret_lat", ret_cyc_q[0] - rel_cyc, 32'd3);
      for (int i = 0; i < 22; i++) begin
         chk($sformatf("ret_pc[%0d]", i), ret_pc_q[i], exp_pc[i]);
         if (i > 0) chk($sformatf("ret_gap[%0d]", i), ret_cyc_q[i] - ret_cyc_q[i-1], exp_gap[i]);
      end
      chk("mem8_x3", mem_words[2], 32'h0000_0002);
      chk("mem12_x4", mem_words[3], 32'hFFFF_FFF8);
      chk("mem16_x5", mem_words[4], 32'h0000_0001);
      chk("mem20_x6", mem_words[5], 32'h0000_0002);
      chk("mem24_x8", mem_words[6], 32'h0000_0000);
      chk("mem28_sra", mem_words[7], 32'hFFFF_FFFF);
      chk("mem32_srl", mem_words[8], 32'h07FF_FFFF);
      chk("stall_cycles", stall_cycles, 32'd6);
      chk("stall_stable", stable_err, 32'd0);
      chk("halt_no_memreq", last_req_addr, 32'h15C);
      chk("halt_delay", halt_cyc - ret_cyc_q[21], 32'd4);
      chk("halt_x7_kept", dut.rf_reg[7], 32'h55);
      chk("halt_req_idle", {31'b0, mem_req}, 32'd0);

      // Illegal opcode 0x7F at the reset PC
      @(negedge clk);
      rst = 1'b0;
      mem_words[64] = 32'h0000_007F;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_clears_halt", {31'b0, halted}, 32'd0);
      ret_before = ret_pc_q.size();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10 && !halted; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      #1;
      chk("illegal_halted", {31'b0, halted}, 32'd1);
      chk("illegal_no_retire", ret_pc_q.size() - ret_before, 32'd0);

      // Reset asserted while a lw is stalled in MEM
      @(negedge clk);
      rst = 1'b0;
      mem_words[64] = enc_i(OP_LOAD, 2, 1, 0, 8);       // lw x1,8(x0)
      stall_n = 1000;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         #1;
         if (mem_req && mem_addr == 32'd8) found = 1'b1;
      end
      chk("abort_reached_mem", {31'b0, found}, 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_req_drop", {31'b0, mem_req}, 32'd0);
      stall_n = 0;
      ret_before = ret_pc_q.size();
      @(negedge clk);
      #1;
      chk("abort_no_write", dut.rf_reg[1], 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("restart_req", {31'b0, mem_req}, 32'd1);
      chk("restart_addr", mem_addr, 32'h100);
      for (int i = 0; i < 20 && ret_pc_q.size() == ret_before; i++) @(negedge clk);
      #1;
      chk("restart_retired", ret_pc_q.size() - ret_before, 32'd1);
      chk("restart_lw_x1", dut.rf_reg[1], 32'd2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
